// File: rtl/cache_controller.sv
// cache_controller
// Direct-mapped, write-through, no-write-allocate L1 controller between the
// CPU load/store port and a 4-word-burst data memory.
//
// Ports
//   CLK, RST          clock (rising edge), asynchronous active-low reset
//   i_CpuAddr         CPU word address {tag, index, offset[1:0]}
//   i_CpuWData        CPU store data
//   i_CpuRead         load request (level, held while o_Stall=1)
//   i_CpuWrite        store request (level, held while o_Stall=1)
//   o_CpuRData        load data, valid when i_CpuRead=1 and o_Stall=0
//   o_Stall           CPU must hold its request
//   o_Hit             read hit or write hit seen in IDLE
//   o_MemAddr         registered memory request address
//   o_MemWData        registered store word
//   o_MemRead         burst read command
//   o_MemWrite        write command
//   o_Count           beat counter to memory
//   i_MemReady        memory burst complete
//   i_MemRData        128-bit line from memory, valid with i_MemReady
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | serve read hits, launch a refill or a write-through
// RD_BURST | 4-beat line read from memory, install on completion
// WR_BURST | forward the registered store word to memory
// DONE     | one-cycle release of the CPU (load data from the new line)
module cache_controller #(
    parameter int ADDR_BITS  = 10,
    parameter int INDEX_BITS = 5
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [ADDR_BITS-1:0] i_CpuAddr,
    input  logic [31:0]          i_CpuWData,
    input  logic                 i_CpuRead,
    input  logic                 i_CpuWrite,
    output logic [31:0]          o_CpuRData,
    output logic                 o_Stall,
    output logic                 o_Hit,
    output logic [ADDR_BITS-1:0] o_MemAddr,
    output logic [31:0]          o_MemWData,
    output logic                 o_MemRead,
    output logic                 o_MemWrite,
    output logic [1:0]           o_Count,
    input  logic                 i_MemReady,
    input  logic [127:0]         i_MemRData
);

    localparam int TAG_BITS = ADDR_BITS - INDEX_BITS - 2;
    localparam int LINES    = 1 << INDEX_BITS;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_RD_BURST = 2'd1,
        S_WR_BURST = 2'd2,
        S_DONE     = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [LINES-1:0]    r_valid;
    logic [TAG_BITS-1:0] r_tag  [LINES];
    logic [127:0]        r_data [LINES];

    logic [1:0]           r_count;
    logic                 r_beats_done;
    logic [ADDR_BITS-1:0] r_MemAddr;
    logic [31:0]          r_MemWData;

    logic [INDEX_BITS-1:0] w_cpu_index;
    logic [TAG_BITS-1:0]   w_cpu_tag;
    logic [1:0]            w_cpu_off;
    logic                  w_lookup_hit;
    logic [127:0]          w_cpu_line;
    logic [31:0]           w_cpu_word;
    logic [INDEX_BITS-1:0] w_mem_index;
    logic [TAG_BITS-1:0]   w_mem_tag;
    logic [1:0]            w_mem_off;
    logic [127:0]          w_mem_line;
    logic [31:0]           w_mem_word;
    logic                  w_burst_exit;

    assign w_cpu_index  = i_CpuAddr[INDEX_BITS+1:2];
    assign w_cpu_tag    = i_CpuAddr[ADDR_BITS-1:INDEX_BITS+2];
    assign w_cpu_off    = i_CpuAddr[1:0];
    assign w_lookup_hit = r_valid[w_cpu_index] && (r_tag[w_cpu_index] == w_cpu_tag);
    assign w_cpu_line   = r_data[w_cpu_index];
    assign w_cpu_word   = w_cpu_line[{w_cpu_off, 5'b00000} +: 32];

    assign w_mem_index  = r_MemAddr[INDEX_BITS+1:2];
    assign w_mem_tag    = r_MemAddr[ADDR_BITS-1:INDEX_BITS+2];
    assign w_mem_off    = r_MemAddr[1:0];
    assign w_mem_line   = r_data[w_mem_index];
    assign w_mem_word   = w_mem_line[{w_mem_off, 5'b00000} +: 32];

    // A Ready left over from an earlier burst is ignored: the beat counter
    // must have driven 3 and wrapped back to 0 before the burst may end.
    assign w_burst_exit = i_MemReady && r_beats_done && (r_count == 2'd0);

    // State register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_CpuWrite)                      w_next = S_WR_BURST;
                else if (i_CpuRead && !w_lookup_hit) w_next = S_RD_BURST;
            end
            S_RD_BURST: if (w_burst_exit) w_next = S_DONE;
            S_WR_BURST: if (w_burst_exit) w_next = S_DONE;
            default:    w_next = S_IDLE;
        endcase
    end

    // Request registers and beat counter
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_count      <= 2'd0;
            r_beats_done <= 1'b0;
            r_MemAddr    <= '0;
            r_MemWData   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_count      <= 2'd0;
                    r_beats_done <= 1'b0;
                    if (i_CpuWrite) begin
                        r_MemAddr  <= i_CpuAddr;
                        r_MemWData <= i_CpuWData;
                    end else if (i_CpuRead && !w_lookup_hit) begin
                        r_MemAddr  <= i_CpuAddr;
                    end
                end
                S_RD_BURST, S_WR_BURST: begin
                    if (w_burst_exit) begin
                        r_count      <= 2'd0;
                        r_beats_done <= 1'b0;
                    end else begin
                        r_count <= r_count + 2'd1;
                        if (r_count == 2'd3) r_beats_done <= 1'b1;
                    end
                end
                default: begin
                    r_count      <= 2'd0;
                    r_beats_done <= 1'b0;
                end
            endcase
        end
    end

    // Valid bits are the only cache state that reset must clear
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_valid <= '0;
        end else if (r_state == S_RD_BURST && w_burst_exit) begin
            r_valid[w_mem_index] <= 1'b1;
        end
    end

    // Tag and data arrays; a write hit patches one word, a refill replaces
    // the whole line (evicting whatever held that index).
    always_ff @(posedge CLK) begin
        if (r_state == S_RD_BURST && w_burst_exit) begin
            r_tag[w_mem_index]  <= w_mem_tag;
            r_data[w_mem_index] <= i_MemRData;
        end else if (r_state == S_IDLE && i_CpuWrite && w_lookup_hit) begin
            r_data[w_cpu_index][{w_cpu_off, 5'b00000} +: 32] <= i_CpuWData;
        end
    end

    // Output logic
    always_comb begin
        o_Stall    = 1'b0;
        o_Hit      = 1'b0;
        o_CpuRData = '0;
        o_MemRead  = 1'b0;
        o_MemWrite = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_CpuWrite) begin
                    o_Stall = 1'b1;
                    o_Hit   = w_lookup_hit;
                end else if (i_CpuRead) begin
                    if (w_lookup_hit) begin
                        o_Hit      = 1'b1;
                        o_CpuRData = w_cpu_word;
                    end else begin
                        o_Stall    = 1'b1;
                    end
                end
            end
            S_RD_BURST: begin
                o_MemRead = 1'b1;
                o_Stall   = 1'b1;
            end
            S_WR_BURST: begin
                o_MemWrite = 1'b1;
                o_Stall    = 1'b1;
            end
            default: o_CpuRData = w_mem_word;
        endcase
        // CPU-facing outputs are forced quiet while reset is held, even if
        // the CPU keeps a request asserted.
        if (!RST) begin
            o_Stall    = 1'b0;
            o_Hit      = 1'b0;
            o_CpuRData = '0;
        end
    end

    assign o_Count    = r_count;
    assign o_MemAddr  = r_MemAddr;
    assign o_MemWData = r_MemWData;

endmodule

// File: tb/tb_cache_controller.sv
module tb_cache_controller;

    logic         CLK = 1'b0;
    logic         RST;
    logic [9:0]   CpuAddr;
    logic [31:0]  CpuWData;
    logic         CpuRead;
    logic         CpuWrite;
    logic [31:0]  CpuRData;
    logic         Stall;
    logic         Hit;
    logic [9:0]   MemAddr;
    logic [31:0]  MemWData;
    logic         MemRead;
    logic         MemWrite;
    logic [1:0]   Count;
    logic         MemReady;
    logic [127:0] MemRData;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    cache_controller #(.ADDR_BITS(10), .INDEX_BITS(5)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .i_CpuAddr  (CpuAddr),
        .i_CpuWData (CpuWData),
        .i_CpuRead  (CpuRead),
        .i_CpuWrite (CpuWrite),
        .o_CpuRData (CpuRData),
        .o_Stall    (Stall),
        .o_Hit      (Hit),
        .o_MemAddr  (MemAddr),
        .o_MemWData (MemWData),
        .o_MemRead  (MemRead),
        .o_MemWrite (MemWrite),
        .o_Count    (Count),
        .i_MemReady (MemReady),
        .i_MemRData (MemRData)
    );

    // Memory: registered Ready one cycle after Count=3 is sampled with a
    // command high; cleared when sampled high together with a command.
    logic [31:0] mem [1024];
    logic [9:0]  mem_base;
    assign mem_base = {MemAddr[9:2], 2'b00};
    assign MemRData = {mem[mem_base + 10'd3], mem[mem_base + 10'd2],
                       mem[mem_base + 10'd1], mem[mem_base]};

    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            MemReady <= 1'b0;
        end else begin
            if (MemWrite) mem[MemAddr] <= MemWData;
            if (MemReady && (MemRead || MemWrite))              MemReady <= 1'b0;
            else if ((MemRead || MemWrite) && Count == 2'd3)    MemReady <= 1'b1;
        end
    end

    // Reference model: expected memory image and which line holds which tag
    logic [31:0] ref_mem   [1024];
    logic        ref_valid [32];
    logic [2:0]  ref_tag   [32];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One CPU transaction, checked against the model's hit/miss prediction
    task automatic do_txn(input bit is_write, input logic [9:0] a, input logic [31:0] d);
        logic [4:0] idx;
        logic [2:0] tg;
        bit         exp_hit;
        int         stall_n, rd_n, wr_n;
        logic [9:0] seq;
        bit         done;
        idx = a[6:2];
        tg  = a[9:7];
        exp_hit = ref_valid[idx] && (ref_tag[idx] == tg);
        @(posedge CLK); #1;
        CpuAddr  = a;
        CpuWData = d;
        CpuRead  = !is_write;
        CpuWrite = is_write;
        @(negedge CLK);
        if (!is_write && exp_hit) begin
            chk("rdhit_stall", Stall, 0);
            chk("rdhit_hit", Hit, 1);
            chk("rdhit_data", CpuRData, ref_mem[a]);
            chk("rdhit_memread", MemRead, 0);
        end else begin
            chk("req_stall", Stall, 1);
            chk("req_hit", Hit, exp_hit);
            stall_n = 1; rd_n = 0; wr_n = 0; seq = '0; done = 0;
            for (int i = 0; i < 30 && !done; i++) begin
                @(negedge CLK);
                if (Stall) begin
                    stall_n++;
                    if (MemRead)  begin rd_n++; seq = {seq[7:0], Count}; end
                    if (MemWrite) begin wr_n++; seq = {seq[7:0], Count}; end
                end else begin
                    done = 1;
                end
            end
            chk("burst_timeout", done, 1);
            chk("stall_cycles", stall_n, 6);
            chk("rd_cycles", rd_n, is_write ? 0 : 5);
            chk("wr_cycles", wr_n, is_write ? 5 : 0);
            chk("count_seq", seq, 10'b00_01_10_11_00);
            chk("done_cmds", {MemRead, MemWrite, Count}, 0);
            chk("done_memaddr", MemAddr, a);
            if (is_write) begin
                ref_mem[a] = d;
                chk("mem_written", mem[a], d);
                chk("done_memwdata", MemWData, d);
            end else begin
                chk("done_rdata", CpuRData, ref_mem[a]);
                ref_valid[idx] = 1'b1;
                ref_tag[idx]   = tg;
            end
        end
        @(posedge CLK); #1;
        CpuRead  = 1'b0;
        CpuWrite = 1'b0;
    endtask

    initial begin
        logic [31:0] v;
        bit          done;
        RST = 1'b0; CpuAddr = '0; CpuWData = '0; CpuRead = 1'b0; CpuWrite = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            v = $urandom;
            if (i >= 4 && i <= 7) v = 32'hA0 + 32'(i - 4);
            mem[i] = v;
            ref_mem[i] = v;
        end
        for (int i = 0; i < 32; i++) begin ref_valid[i] = 1'b0; ref_tag[i] = '0; end

        #3;
        chk("rst_cmds", {MemRead, MemWrite, Count, Stall, Hit}, 0);
        chk("rst_memaddr", MemAddr, 0);
        chk("rst_memwdata", MemWData, 0);
        chk("rst_rdata", CpuRData, 0);
        @(negedge CLK); RST = 1'b1;

        // Directed: cold miss, hit, write hit, write miss, conflict eviction
        do_txn(0, 10'h004, 0);
        do_txn(0, 10'h006, 0);
        do_txn(1, 10'h005, 32'h1234);
        do_txn(0, 10'h005, 0);
        do_txn(1, 10'h3F0, 32'hBEEF);
        do_txn(0, 10'h3F0, 0);
        do_txn(0, 10'h004, 0);
        do_txn(0, 10'h084, 0);
        do_txn(0, 10'h004, 0);

        // Reset in the middle of a refill at Count=2
        @(posedge CLK); #1;
        CpuAddr = 10'h010; CpuRead = 1'b1;
        done = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge CLK);
            if (MemRead && Count == 2'd2) done = 1;
        end
        chk("midburst_reach", done, 1);
        #2 RST = 1'b0;
        #1;
        chk("midrst_memread", MemRead, 0);
        chk("midrst_count", Count, 0);
        chk("midrst_stall", Stall, 0);
        chk("midrst_hit", Hit, 0);
        CpuRead = 1'b0;
        for (int i = 0; i < 32; i++) ref_valid[i] = 1'b0;
        @(negedge CLK); @(negedge CLK); RST = 1'b1;
        do_txn(0, 10'h004, 0);

        // Random mix over a few indices/tags so hits, misses and evictions occur
        for (int n = 0; n < 40; n++) begin
            logic [9:0] a;
            a = {3'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
            do_txn(1'($urandom_range(0, 1)), a, $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
